// File: rtl/bitser_pkg.sv
// Shared types and constants for the bit-packet serializer.
// The package itself has no build options.
package bitser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_shift_reg.sv
// Loadable shift register that presents one bit per shift, MSB or LSB end first.
// The shift register itself has no build options.
module bit_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_q;

  // A load always wins, so a refill on the last-bit beat replaces the shift.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      if (MSB_FIRST) r_q <= {r_q[WIDTH-2:0], 1'b0};
      else           r_q <= {1'b0, r_q[WIDTH-1:1]};
    end
  end

  assign o_bit = MSB_FIRST ? r_q[WIDTH-1] : r_q[0];

endmodule

// File: rtl/bitpacket_serializer.sv
// Word-to-bit serializer with packet framing and a sticky framing error flag.
// Define BITSER_PARITY_EN to append an even-parity bit carrying o_eop to each packet.
module bitpacket_serializer
  import bitser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [$clog2(WIDTH+1)-1:0] i_nbits,
  input  logic                       i_valid,
  input  logic                       i_sop,
  input  logic                       i_eop,
  output logic                       i_ready,
  output logic                       outp,
  output logic                       o_valid,
  output logic                       o_sop,
  output logic                       o_eop,
  input  logic                       o_ready,
  output logic                       o_err
);

  localparam int CW = CNT_W(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_sop;
  logic             r_eop;
  logic             r_in_pkt;
  logic             r_err;
  logic             w_ready;
  logic             w_beat;
  logic             w_shift;
  logic             w_last;
  logic             w_acc;
  logic             w_load;
  logic             w_bit;
  logic [CW-1:0]    w_nload;
  logic [WIDTH-1:0] w_ldata;

  assign w_beat  = o_valid & o_ready;
  assign w_shift = w_beat & (r_state == SHIFT);
  assign w_last  = (r_state == SHIFT) && (r_cnt == CW'(1));
  assign i_ready = reset_n & w_ready;
  assign w_acc   = i_valid & i_ready;
  // A word is only loaded when it starts a packet or continues an open one.
  assign w_load  = w_acc & (i_sop | r_in_pkt);
  assign w_nload = (i_eop && (i_nbits != '0)) ? i_nbits : CW'(WIDTH);
  assign w_ldata = MSB_FIRST ? (i_data << (CW'(WIDTH) - w_nload)) : i_data;

  bit_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_ldata),
    .o_bit   (w_bit)
  );

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:  w_ready = 1'b1;
`ifdef BITSER_PARITY_EN
      SHIFT: w_ready = w_beat & w_last & ~r_eop;
`else
      SHIFT: w_ready = w_beat & w_last;
`endif
      default: w_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_load) w_next = SHIFT;
      SHIFT: begin
        if (w_beat && w_last) begin
`ifdef BITSER_PARITY_EN
          if (r_eop)       w_next = PARITY;
          else if (w_load) w_next = SHIFT;
          else             w_next = IDLE;
`else
          w_next = w_load ? SHIFT : IDLE;
`endif
        end
      end
`ifdef BITSER_PARITY_EN
      PARITY: if (w_beat) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_in_pkt <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cnt    <= w_nload;
        r_sop    <= i_sop;
        r_eop    <= i_eop;
        r_in_pkt <= ~i_eop;
      end else if (w_shift) begin
        r_cnt <= r_cnt - CW'(1);
        r_sop <= 1'b0;
      end
      if (w_acc && ((i_sop && r_in_pkt) || (!i_sop && !r_in_pkt) ||
                    (!i_eop && (i_nbits != '0)))) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef BITSER_PARITY_EN
  logic r_par;

  // Running XOR of the packet's data bits; a new packet restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_par <= 1'b0;
    end else if (w_load && i_sop) begin
      r_par <= 1'b0;
    end else if (w_shift) begin
      r_par <= r_par ^ w_bit;
    end
  end

  assign o_valid = (r_state == SHIFT) || (r_state == PARITY);
  assign outp    = (r_state == PARITY) ? r_par : (o_valid & w_bit);
  assign o_eop   = (r_state == PARITY);
`else
  assign o_valid = (r_state == SHIFT);
  assign outp    = o_valid & w_bit;
  assign o_eop   = w_last & r_eop;
`endif

  assign o_sop = (r_state == SHIFT) & r_sop;
  assign o_err = r_err;

endmodule

// File: tb/tb_bitpacket_serializer.sv
// Scoreboard bench for bitpacket_serializer (WIDTH=8, MSB_FIRST=1).
// Honours BITSER_PARITY_EN in its expected-bit model.
module tb_bitpacket_serializer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] i_data = '0;
  logic [3:0] i_nbits = '0;
  logic       i_valid = 1'b0;
  logic       i_sop = 1'b0;
  logic       i_eop = 1'b0;
  logic       i_ready;
  logic       outp;
  logic       o_valid;
  logic       o_sop;
  logic       o_eop;
  logic       o_ready = 1'b1;
  logic       o_err;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] nbits;
    logic       sop;
    logic       eop;
  } word_t;

  word_t      drvQ[$];
  logic [2:0] expQ[$];
  int         checks = 0;
  int         failures = 0;
  bit         mInPkt = 1'b0;
  bit         mPar = 1'b0;
  bit         accNow = 1'b0;

  bitpacket_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_data  (i_data),
    .i_nbits (i_nbits),
    .i_valid (i_valid),
    .i_sop   (i_sop),
    .i_eop   (i_eop),
    .i_ready (i_ready),
    .outp    (outp),
    .o_valid (o_valid),
    .o_sop   (o_sop),
    .o_eop   (o_eop),
    .o_ready (o_ready),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  // Queue a word for the driver and predict the bits it should produce.
  function automatic void pushWord(input logic [7:0] data, input logic [3:0] nbits,
                                   input logic sop, input logic eop);
    int  n;
    bit  b;
    bit  lastEop;
    drvQ.push_back('{data, nbits, sop, eop});
    if (!sop && !mInPkt) return;
    if (sop) mPar = 1'b0;
    n = (eop && nbits != 0) ? int'(nbits) : 8;
`ifdef BITSER_PARITY_EN
    lastEop = 1'b0;
`else
    lastEop = eop;
`endif
    for (int i = n - 1; i >= 0; i--) begin
      b = data[i];
      expQ.push_back({b, sop && (i == n - 1), lastEop && (i == 0)});
      mPar = mPar ^ b;
    end
`ifdef BITSER_PARITY_EN
    if (eop) expQ.push_back({mPar, 1'b0, 1'b1});
`endif
    mInPkt = !eop;
  endfunction

  // Word driver: presents queued words and retires them once accepted.
  initial begin
    word_t w;
    forever begin
      @(posedge clk);
      #1;
      if (accNow) i_valid = 1'b0;
      if (!i_valid && drvQ.size() > 0) begin
        w = drvQ.pop_front();
        i_data  = w.data;
        i_nbits = w.nbits;
        i_sop   = w.sop;
        i_eop   = w.eop;
        i_valid = 1'b1;
      end
      #7;
      accNow = i_valid && i_ready;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b0) begin failures++; $display("FAIL reset_iready got %b exp 0", i_ready); end
    checks++;
    if ({o_valid, o_sop, o_eop, outp, o_err} !== 5'b0) begin
      failures++; $display("FAIL reset_outs got %b exp 00000", {o_valid, o_sop, o_eop, outp, o_err});
    end
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("FAIL release_iready got %b exp 1", i_ready); end
  endtask

  task automatic test_single_word();
    int n, got, cyc;
    logic [2:0] e;
    pushWord(8'hA5, 4'd0, 1'b1, 1'b1);
    n = expQ.size(); got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (o_valid && o_ready) begin
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL word_a5 bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    checks++;
    if (got < n) begin failures++; $display("FAIL word_a5 timeout got %0d bits exp %0d", got, n); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL word_a5 idle got o_valid %b exp 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    int n, got, cyc;
    logic [2:0] e;
    pushWord(8'hFF, 4'd0, 1'b1, 1'b0);
    pushWord(8'h03, 4'd2, 1'b0, 1'b1);
    n = expQ.size(); got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (got > 0) begin
        checks++;
        if (o_valid !== 1'b1) begin failures++; $display("FAIL b2b gap at bit%0d got o_valid %b exp 1", got, o_valid); end
      end
      if (o_valid && o_ready) begin
        if (got == 7) begin
          checks++;
          if (i_ready !== 1'b1) begin failures++; $display("FAIL b2b iready_last got %b exp 1", i_ready); end
        end
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL b2b bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    checks++;
    if (got < n) begin failures++; $display("FAIL b2b timeout got %0d bits exp %0d", got, n); end
  endtask

  task automatic test_stall();
    int n, got, cyc;
    logic [2:0] e;
    bit pat [12] = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1};
    pushWord(8'hC3, 4'd0, 1'b1, 1'b1);
    n = expQ.size(); got = 0; cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      o_ready = pat[cyc % 12];
      #1; cyc++;
      if (o_valid && !o_ready && expQ.size() > 0) begin
        checks++;
        if ({outp, o_sop, o_eop} !== expQ[0]) begin
          failures++; $display("FAIL stall_hold bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, expQ[0]);
        end
      end
      if (o_valid && o_ready) begin
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL stall bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    checks++;
    if (got < n) begin failures++; $display("FAIL stall timeout got %0d bits exp %0d", got, n); end
    @(negedge clk); o_ready = 1'b1; #1;
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL stall extra_bit got o_valid %b exp 0", o_valid); end
  endtask

  task automatic test_single_bit();
    int n, got, cyc;
    logic [2:0] e;
    pushWord(8'h80, 4'd1, 1'b1, 1'b1);
    n = expQ.size(); got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (o_valid && o_ready) begin
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL single_bit beat%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    checks++;
    if (got < n) begin failures++; $display("FAIL single_bit timeout got %0d exp %0d", got, n); end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("FAIL single_bit idle got o_valid %b exp 0", o_valid); end
  endtask

`ifdef BITSER_PARITY_EN
  task automatic test_parity();
    int n, got, cyc;
    logic [2:0] e;
    pushWord(8'h07, 4'd0, 1'b1, 1'b1);
    n = expQ.size(); got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (o_valid && o_ready) begin
        if (got == 8) begin
          checks++;
          if ({outp, o_sop, o_eop, i_ready} !== 4'b1010) begin
            failures++; $display("FAIL parity_beat got %b exp 1010", {outp, o_sop, o_eop, i_ready});
          end
        end
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL parity bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    checks++;
    if (got != 9) begin failures++; $display("FAIL parity count got %0d exp 9", got); end
  endtask
`endif

  task automatic test_framing();
    int n, got, cyc;
    logic [2:0] e;
    checks++;
    if (o_err !== 1'b0) begin failures++; $display("FAIL err_clean got %b exp 0", o_err); end
    pushWord(8'hF0, 4'd0, 1'b1, 1'b0);
    pushWord(8'h0F, 4'd0, 1'b1, 1'b1);
    n = expQ.size(); got = 0; cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk); #1; cyc++;
      if (o_valid && o_ready) begin
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL framing bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    checks++;
    if (got < n) begin failures++; $display("FAIL framing timeout got %0d exp %0d", got, n); end
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL err_sop_mid got %b exp 1", o_err); end
    pushWord(8'hAA, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL stray_word emitted at cycle %0d got o_valid %b exp 0", k, o_valid); end
    end
    checks++;
    if (drvQ.size() != 0 || i_valid !== 1'b0) begin
      failures++; $display("FAIL stray_word not_accepted got pending %0d exp 0", drvQ.size());
    end
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL err_sticky got %b exp 1", o_err); end
  endtask

  task automatic test_mid_reset();
    int got, cyc;
    logic [2:0] e;
    pushWord(8'hA5, 4'd0, 1'b1, 1'b1);
    got = 0; cyc = 0;
    while (got < 3 && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (o_valid && o_ready) begin
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL midreset bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    @(posedge clk); #2;
    reset_n = 1'b0; i_valid = 1'b0;
    drvQ.delete(); expQ.delete(); mInPkt = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({o_valid, o_eop, i_ready} !== 3'b000) begin
      failures++; $display("FAIL midreset outs got %b exp 000", {o_valid, o_eop, i_ready});
    end
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_ready, o_valid, o_err} !== 3'b100) begin
      failures++; $display("FAIL midreset release got %b exp 100", {i_ready, o_valid, o_err});
    end
  endtask

  task automatic test_nbits_err();
    int n, got, cyc;
    logic [2:0] e;
    pushWord(8'h5A, 4'd3, 1'b1, 1'b0);
    pushWord(8'h01, 4'd1, 1'b0, 1'b1);
    n = expQ.size(); got = 0; cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk); #1; cyc++;
      if (o_valid && o_ready) begin
        e = expQ.pop_front(); checks++;
        if ({outp, o_sop, o_eop} !== e) begin
          failures++; $display("FAIL nbits_err bit%0d got %b exp %b", got, {outp, o_sop, o_eop}, e);
        end
        got++;
      end
    end
    checks++;
    if (got < n) begin failures++; $display("FAIL nbits_err timeout got %0d exp %0d", got, n); end
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL nbits_err flag got %b exp 1", o_err); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_single_bit();
`ifdef BITSER_PARITY_EN
    test_parity();
`endif
    test_framing();
    test_mid_reset();
    test_nbits_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
